// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   - fetch_state_e : sequencer states
//   - FETCH_AW / FETCH_RESET_PC / FETCH_JW : parameter defaults
//   - NOP           : value held in the instruction register after reset
//   - sat_inc       : saturating 32-bit increment (performance counters)
package fetch_pkg;

    localparam int          FETCH_AW       = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0;
    localparam int          FETCH_JW       = 26;
    localparam logic [31:0] NOP            = 32'h0;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational redirect target computation.
//   br_valid_i/br_pc_i/br_offset_i : taken branch, target = br_pc + 1 + sext(offset)
//   j_valid_i/j_target_i           : jump, target = {pc_i[AW-1:JW], j_target}
//   pc_i                           : current PC register (jump region)
//   redir_o                        : any redirect this cycle
//   target_o                       : selected target, branch has priority
module fetch_target_calc #(
    parameter int AW = 32,
    parameter int JW = 26
) (
    input  logic          br_valid_i,
    input  logic [AW-1:0] br_pc_i,
    input  logic [15:0]   br_offset_i,
    input  logic          j_valid_i,
    input  logic [JW-1:0] j_target_i,
    input  logic [AW-1:0] pc_i,
    output logic          redir_o,
    output logic [AW-1:0] target_o
);

    logic [AW-1:0] br_tgt;
    logic [AW-1:0] j_tgt;

    assign br_tgt = br_pc_i + AW'(1) + {{(AW-16){br_offset_i[15]}}, br_offset_i};
    // Masking keeps the upper PC region and splices in the jump field.
    assign j_tgt  = (pc_i & {{(AW-JW){1'b1}}, {JW{1'b0}}}) | {{(AW-JW){1'b0}}, j_target_i};

    assign redir_o  = br_valid_i | j_valid_i;
    assign target_o = br_valid_i ? br_tgt : j_tgt;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the word-addressed PC, issues req/ack
// reads to instruction memory, hands instructions to decode via valid/ready
// and applies branch/jump redirects (also while a read is outstanding).
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   imem_req/addr/ack/rdata : instruction memory read interface
//   instr_valid/instr/instr_pc/instr_ready : decode handshake
//   br_valid/br_pc/br_offset, j_valid/j_target : redirects
//   halt / halted           : stop issuing fetches / idle indication
// Optional: `define FETCH_PERF_EN adds perf_fetched, perf_stall,
// perf_redirects saturating 32-bit counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          AW       = FETCH_AW,
    parameter logic [AW-1:0] RESET_PC = AW'(FETCH_RESET_PC),
    parameter int          JW       = FETCH_JW
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    output logic [31:0]   instr,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    input  logic          br_valid,
    input  logic [AW-1:0] br_pc,
    input  logic [15:0]   br_offset,
    input  logic          j_valid,
    input  logic [JW-1:0] j_target,
    input  logic          halt,
`ifdef FETCH_PERF_EN
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_redirects,
`endif
    output logic          halted
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pend_q, pend_d;
    logic          gap_q, gap_d;   // suppresses the request for one cycle
    logic [31:0]   instr_q, instr_d;
    logic [AW-1:0] instr_pc_q, instr_pc_d;

    logic          redir;
    logic [AW-1:0] redir_tgt;
    logic          ack_ok;
    logic          xfer;

    fetch_target_calc #(.AW(AW), .JW(JW)) u_tgt (
        .br_valid_i  (br_valid),
        .br_pc_i     (br_pc),
        .br_offset_i (br_offset),
        .j_valid_i   (j_valid),
        .j_target_i  (j_target),
        .pc_i        (pc_q),
        .redir_o     (redir),
        .target_o    (redir_tgt)
    );

    assign imem_req    = !reset && (((state_q == FETCH) && !gap_q) || (state_q == SQUASH));
    assign imem_addr   = pc_q;
    assign ack_ok      = imem_req && imem_ack;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = (state_q == HALTED);
    assign xfer        = instr_valid && instr_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        gap_d      = 1'b0;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            FETCH: begin
                if (redir) begin
                    if (!imem_req) begin
                        pc_d = redir_tgt;            // nothing outstanding
                    end else if (ack_ok) begin
                        pc_d  = redir_tgt;           // drop data, idle one cycle
                        gap_d = 1'b1;
                    end else begin
                        pend_d  = redir_tgt;         // keep old address until ack
                        state_d = SQUASH;
                    end
                end else if (ack_ok) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + AW'(1);
                    state_d    = HOLD;
                end
            end
            SQUASH: begin
                if (redir) pend_d = redir_tgt;
                if (ack_ok) begin
                    pc_d    = redir ? redir_tgt : pend_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redir) pc_d = redir_tgt;
                if (xfer)       state_d = halt ? HALTED : FETCH;
                else if (redir) state_d = FETCH;
            end
            HALTED: begin
                if (redir) pc_d = redir_tgt;
                if (!halt) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            gap_q      <= 1'b1;
            instr_q    <= NOP;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            gap_q      <= gap_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q, perf_redirects_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q   <= '0;
            perf_stall_q     <= '0;
            perf_redirects_q <= '0;
        end else begin
            perf_fetched_q   <= sat_inc(perf_fetched_q, xfer);
            perf_stall_q     <= sat_inc(perf_stall_q,
                                        ((state_q == FETCH) || (state_q == SQUASH)) && !ack_ok);
            perf_redirects_q <= sat_inc(perf_redirects_q, redir);
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_stall     = perf_stall_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        br_valid;
    logic [31:0] br_pc;
    logic [15:0] br_offset;
    logic        j_valid;
    logic [25:0] j_target;
    logic        halt;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_redirects;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.AW(32), .RESET_PC(32'h0), .JW(26)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .j_valid     (j_valid),
        .j_target    (j_target),
        .halt        (halt),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_redirects (perf_redirects),
`endif
        .halted      (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One fetch with single-cycle ack and ready=1: request, hold, transfer.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        chk("fetch_req", {63'd0, imem_req}, 64'd1);
        chk("fetch_addr", {32'd0, imem_addr}, {32'd0, addr});
        imem_ack = 1'b1; imem_rdata = data;
        step();
        imem_ack = 1'b0;
        chk("hold_valid", {63'd0, instr_valid}, 64'd1);
        chk("hold_instr", {32'd0, instr}, {32'd0, data});
        chk("hold_pc", {32'd0, instr_pc}, {32'd0, addr});
        step();
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
        br_valid = 1'b0; br_pc = '0; br_offset = '0; j_valid = 1'b0; j_target = '0;
        halt = 1'b0;
        step(); step();
        reset = 1'b0;

        // Reset state: first cycle after reset has no request.
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        step();

        // Sequential fetch 0..3, one instruction every two cycles.
        for (int i = 0; i < 4; i++) fetch_one(32'(i), 32'hA0 + 32'(i));

        // Decode stall for 5 cycles.
        instr_ready = 1'b0;
        chk("stall_addr", {32'd0, imem_addr}, 64'd4);
        imem_ack = 1'b1; imem_rdata = 32'hB4;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {63'd0, instr_valid}, 64'd1);
            chk("stall_instr", {32'd0, instr}, 64'hB4);
            chk("stall_pc", {32'd0, instr_pc}, 64'd4);
            chk("stall_req", {63'd0, imem_req}, 64'd0);
            step();
        end
        instr_ready = 1'b1;
        step();
        chk("unstall_valid", {63'd0, instr_valid}, 64'd0);
        for (int i = 5; i < 11; i++) fetch_one(32'(i), 32'hC0 + 32'(i));

        // Branch 10 + 1 - 3 = 8 while request at 11 outstanding.
        chk("sq_addr0", {32'd0, imem_addr}, 64'd11);
        br_valid = 1'b1; br_pc = 32'd10; br_offset = 16'hFFFD;
        step();
        br_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("sq_req", {63'd0, imem_req}, 64'd1);
            chk("sq_addr", {32'd0, imem_addr}, 64'd11);
            step();
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD;
        step();
        imem_ack = 1'b0;
        chk("sq_dropped", {63'd0, instr_valid}, 64'd0);
        fetch_one(32'd8, 32'h88);

        // Reach 0x0400_0005 via branch from 0x0400_0000 + 1 + 4.
        br_valid = 1'b1; br_pc = 32'h0400_0000; br_offset = 16'd4;
        step();
        br_valid = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("far_addr", {32'd0, imem_addr}, 64'h0400_0005);
        // Branch + jump + ack together: branch 0x0400_0005+1+0x10 wins.
        br_valid = 1'b1; br_pc = 32'h0400_0005; br_offset = 16'h0010;
        j_valid = 1'b1; j_target = 26'h20;
        imem_ack = 1'b1; imem_rdata = 32'hBAD;
        step();
        br_valid = 1'b0; j_valid = 1'b0; imem_ack = 1'b0;
        chk("both_gap_req", {63'd0, imem_req}, 64'd0);
        chk("both_valid", {63'd0, instr_valid}, 64'd0);
        step();
        fetch_one(32'h0400_0016, 32'h55);

        // Halt during FETCH: instruction still delivered, then halted.
        halt = 1'b1;
        fetch_one(32'h0400_0017, 32'h77);
        chk("halted", {63'd0, halted}, 64'd1);
        chk("halted_req", {63'd0, imem_req}, 64'd0);
        step();
        chk("halted_req2", {63'd0, imem_req}, 64'd0);
        halt = 1'b0;
        step();
        chk("resume_halted", {63'd0, halted}, 64'd0);
        halt = 1'b1;
        fetch_one(32'h0400_0018, 32'h78);
        // Jump while halted: {pc[31:26], 26'h3} with pc = 0x0400_0019.
        j_valid = 1'b1; j_target = 26'h3;
        step();
        j_valid = 1'b0;
        chk("jhalt_halted", {63'd0, halted}, 64'd1);
        halt = 1'b0;
        step();
        chk("jhalt_addr", {32'd0, imem_addr}, 64'h0400_0003);
        chk("jhalt_req", {63'd0, imem_req}, 64'd1);

        // Reset while in SQUASH, ack arrives the cycle after reset.
        br_valid = 1'b1; br_pc = 32'd0; br_offset = 16'd0;
        step();
        br_valid = 1'b0;
        chk("sq2_addr", {32'd0, imem_addr}, 64'h0400_0003);
        reset = 1'b1;
        step();
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hEEEE;
        chk("rst2_req", {63'd0, imem_req}, 64'd0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", {32'd0, perf_fetched}, 64'd0);
        chk("perf_stall", {32'd0, perf_stall}, 64'd0);
        chk("perf_redir", {32'd0, perf_redirects}, 64'd0);
`endif
        step();
        imem_ack = 1'b0;
        chk("rst2_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst2_instr", {32'd0, instr}, 64'd0);
        chk("rst2_req1", {63'd0, imem_req}, 64'd1);
        chk("rst2_addr", {32'd0, imem_addr}, 64'd0);
        step();
        chk("rst2_novalid", {63'd0, instr_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences instruction fetch around the word-addressed program counter. It owns the PC register, issues request/acknowledge reads to instruction memory and hands fetched instructions to decode with a valid/ready handshake. It applies branch and jump redirects, including redirects that arrive while a memory read is still outstanding. It sits between the instruction memory and decode and replaces free-running PC increment with stall-aware sequencing.

Parameters:
AW, 32, PC/address width (word address; sequential step is +1)
RESET_PC, 0, PC value loaded on reset
JW, 26, jump target field width

Ports:
clk  in  1  clock
reset  in  1  reset
imem_req  out  1  read request; held until imem_ack
imem_addr  out  AW  word address; stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid same cycle
imem_rdata  in  32  instruction word
instr_valid  out  1  instruction available to decode
instr  out  32  held instruction
instr_pc  out  AW  PC of held instruction
instr_ready  in  1  decode accepts when instr_valid&instr_ready
br_valid  in  1  taken-branch redirect
br_pc  in  AW  PC of the branch instruction
br_offset  in  16  signed word offset
j_valid  in  1  jump redirect
j_target  in  JW  jump field
halt  in  1  level; stop issuing new fetches
halted  out  1  idle, no request outstanding

Behaviour:
- Reset: sync, active-high, clk rising edge. pc=RESET_PC, state=FETCH, imem_req=0 for the reset cycle, instr_valid=0, instr=0, instr_pc=0, halted=0, pending redirect cleared. Reset mid-request abandons it; an ack arriving the cycle after reset is ignored unless imem_req=1.
- Target arithmetic: branch = br_pc + 1 + sign_extend(br_offset), modulo 2^AW. Jump = {pc[AW-1:JW], j_target}, using the current pc register. Redirect is a single cycle of br_valid or j_valid. Branch wins if both are high in the same cycle.
- States:
  FETCH: imem_req=1, imem_addr=pc.
    - On ack with no redirect this cycle and no pending redirect: capture instr=imem_rdata, instr_pc=pc, pc<=pc+1, go to HOLD.
    - On redirect with no ack: latch the target as pending, go to SQUASH.
    - On redirect with ack in the same cycle: drop the data, pc<=target, stay in FETCH. The request deasserts for one cycle, then a new request is issued.
  SQUASH: imem_req stays 1 with the old address (a request is never withdrawn).
    - On ack: discard the data, pc<=pending target, go to FETCH.
    - A newer redirect overwrites the pending target.
  HOLD: instr_valid=1, imem_req=0.
    - On transfer: go to FETCH, or HALTED if halt=1.
    - On redirect: instr_valid<=0 next cycle, pc<=target, go to FETCH. If a transfer happens in the same cycle, the transfer still counts and the redirect still applies.
  HALTED: halted=1, no requests. Leaves to FETCH on the first cycle with halt=0. A redirect in HALTED updates pc.
- halt in FETCH or SQUASH does not cancel the outstanding request. It takes effect at the HOLD exit.
- Latency: with single-cycle ack and instr_ready=1, one instruction every 2 cycles. No prefetch beyond one.
- instr and instr_pc hold stable while instr_valid=1 and instr_ready=0.

Optional Feature:
FETCH_PERF_EN defined adds three outputs, each 32-bit:
- perf_fetched: increments on each decode transfer.
- perf_stall: increments on each FETCH/SQUASH cycle without ack.
- perf_redirects: increments on each accepted redirect.
All three reset to 0 and saturate at all-ones. Undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg: state enum (FETCH, SQUASH, HOLD, HALTED), RESET_PC/AW defaults, NOP constant 32'h0.
- One sub-module fetch_target_calc: combinational branch/jump target computation and priority select. Reused by verification as a reference model.

Test Plan:
- Reset, ack 1 cycle after each req, instr_ready=1 -> imem_addr sequence 0,1,2,3; instr_pc matches; transfer every 2 cycles.
- In HOLD, instr_ready=0 for 5 cycles -> instr/instr_pc stable, imem_req=0; next transfer occurs on ready.
- br_valid with br_pc=10, br_offset=-3 while request at 11 is pending, ack 3 cycles later -> data discarded, next imem_addr=8, never delivered to decode.
- br_valid and j_valid in the same cycle as ack, pc=0x0400_0005, j_target=0x20 -> branch target taken, ack data dropped, one idle cycle, then req at the branch target.
- halt=1 during FETCH -> current instruction delivered, then halted=1 with no req; halt=0 -> fetch resumes at next pc. Redirect while HALTED -> resumes at the redirect target.
- reset asserted in SQUASH with ack arriving the next cycle -> ack ignored, first req at RESET_PC, instr_valid=0; FETCH_PERF_EN counters read 0.
